// File: rtl/ad3542_spi_tx.sv
// rtl/ad3542_spi_tx.sv - sample FIFO feeding 24-bit AD3542 SPI write frames
module ad3542_spi_tx #(
    parameter int         CLK_DIV  = 2,
    parameter int         CSB_GAP  = 2,
    parameter int         FIFO_AW  = 2,
    parameter logic [6:0] DAC_ADDR = 7'h2A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wave_valid,
    input  logic [15:0] wave_out,
    input  logic        ovf_clear,
    output logic        busy,
    output logic        overflow,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_sdo
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]       GAP_LAST  = 8'(CSB_GAP - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full, push, pop, drop;
    logic [23:0]        frame;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d, gap_q, gap_d;
    logic [5:0]  edge_q, edge_d;
    logic [23:0] shreg_q, shreg_d;
    logic        csb_d, sclk_d, sdo_d;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push  = wave_valid && (!full || pop);
    assign drop  = wave_valid && full && !pop;
    assign frame = {1'b0, DAC_ADDR, mem[rd_ptr]};
    assign busy  = !empty || (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wave_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A drop wins over a simultaneous clear.
            if (drop)           overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            gap_q    <= '0;
            edge_q   <= '0;
            shreg_q  <= '0;
            spi_csb  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            edge_q   <= edge_d;
            shreg_q  <= shreg_d;
            spi_csb  <= csb_d;
            spi_sclk <= sclk_d;
            spi_sdo  <= sdo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        edge_d  = edge_q;
        shreg_d = shreg_q;
        csb_d   = spi_csb;
        sclk_d  = spi_sclk;
        sdo_d   = spi_sdo;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                sdo_d  = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    csb_d   = 1'b0;
                    sdo_d   = frame[23];
                    shreg_d = {frame[22:0], 1'b0};
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~spi_sclk;
                    edge_d = edge_q + 6'd1;
                    // Falling edge: present the next bit, or close the frame on the 24th.
                    if (spi_sclk) begin
                        if (edge_q == 6'd47) begin
                            csb_d   = 1'b1;
                            sclk_d  = 1'b0;
                            sdo_d   = 1'b0;
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            sdo_d   = shreg_q[23];
                            shreg_d = {shreg_q[22:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad3542_spi_tx.sv
// tb/tb_ad3542_spi_tx.sv - scoreboard bench for ad3542_spi_tx (default and fast instances)
module tb_ad3542_spi_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wv0 = 1'b0, oc0 = 1'b0, wv1 = 1'b0, oc1 = 1'b0;
    logic [15:0] wo0 = '0, wo1 = '0;
    logic        busy0, ovf0, csb0, sclk0, sdo0;
    logic        busy1, ovf1, csb1, sclk1, sdo1;

    always #5 clk = ~clk;

    ad3542_spi_tx dut (
        .clk(clk), .reset_n(reset_n), .wave_valid(wv0), .wave_out(wo0), .ovf_clear(oc0),
        .busy(busy0), .overflow(ovf0), .spi_csb(csb0), .spi_sclk(sclk0), .spi_sdo(sdo0)
    );

    ad3542_spi_tx #(.CLK_DIV(1), .CSB_GAP(1)) dut_fast (
        .clk(clk), .reset_n(reset_n), .wave_valid(wv1), .wave_out(wo1), .ovf_clear(oc1),
        .busy(busy1), .overflow(ovf1), .spi_csb(csb1), .spi_sclk(sclk1), .spi_sdo(sdo1)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];
    int          start_q0[$];
    int          start_q1[$];
    logic        prev_csb[2]  = '{1'b1, 1'b1};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_sdo[2]  = '{1'b0, 1'b0};
    logic [23:0] cap[2];
    int          nbits[2] = '{0, 0};
    int          t_low[2] = '{0, 0};
    int          frames[2] = '{0, 0};
    bit          abort_ok = 1'b0;
    int          proto_bad = 0;

    // SPI slave model: samples on SCLK rising edges, scores each frame at CSB rise.
    logic        mc, ms, md;
    logic [23:0] me;
    int          mdur;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mc = (i == 0) ? csb0 : csb1;
            ms = (i == 0) ? sclk0 : sclk1;
            md = (i == 0) ? sdo0 : sdo1;
            if (mc && md) proto_bad++;
            if (!mc && !prev_csb[i] && (md !== prev_sdo[i]) && !(prev_sclk[i] && !ms)) proto_bad++;
            if (!mc && prev_csb[i]) begin
                t_low[i] = cyc;
                nbits[i] = 0;
                cap[i]   = '0;
                if (i == 0) start_q0.push_back(cyc); else start_q1.push_back(cyc);
            end
            if (!mc && ms && !prev_sclk[i]) begin
                cap[i]   = {cap[i][22:0], md};
                nbits[i] = nbits[i] + 1;
            end
            if (mc && !prev_csb[i]) begin
                if (i == 0 && abort_ok) begin
                    abort_ok = 1'b0;
                end else begin
                    frames[i] = frames[i] + 1;
                    checks++;
                    if (nbits[i] !== 24) $display("FAIL frame_bits inst=%0d got %0d required 24", i, nbits[i]);
                    else passed++;
                    mdur = cyc - t_low[i];
                    checks++;
                    if (mdur !== ((i == 0) ? 96 : 48))
                        $display("FAIL csb_low_len inst=%0d got %0d required %0d", i, mdur, (i == 0) ? 96 : 48);
                    else passed++;
                    checks++;
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        $display("FAIL frame_data inst=%0d got %h required none (unexpected frame)", i, cap[i]);
                    end else begin
                        me = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (cap[i] !== me) $display("FAIL frame_data inst=%0d got %h required %h", i, cap[i], me);
                        else passed++;
                    end
                end
            end
            prev_csb[i]  = mc;
            prev_sclk[i] = ms;
            prev_sdo[i]  = md;
        end
    end

    function automatic logic [23:0] word(input logic [15:0] s);
        return {1'b0, 7'h2A, s};
    endfunction

    task automatic wait_idle(input int inst, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((inst == 0) ? (busy0 || !csb0) : (busy1 || !csb1)) && n < budget);
        checks++;
        if (n >= budget) $display("FAIL idle_timeout inst=%0d got busy after %0d cycles required idle", inst, n);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wv0 = 1'b1;
        wo0 = 16'hDEAD;
        repeat (3) @(negedge clk);
        checks++; if (csb0 !== 1'b1) $display("FAIL rst_csb got %b required 1", csb0); else passed++;
        checks++; if (sclk0 !== 1'b0) $display("FAIL rst_sclk got %b required 0", sclk0); else passed++;
        checks++; if (sdo0 !== 1'b0) $display("FAIL rst_sdo got %b required 0", sdo0); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL rst_busy got %b required 0", busy0); else passed++;
        checks++; if (ovf0 !== 1'b0) $display("FAIL rst_ovf got %b required 0", ovf0); else passed++;
        reset_n = 1'b1;
        wv0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) $display("FAIL rst_ignore_valid got busy=%b required 0", busy0); else passed++;
    endtask

    task automatic test_single();
        int f0 = frames[0];
        int c0;
        start_q0.delete();
        exp_q0.push_back(24'h2AA5C3);
        c0 = cyc;
        wv0 = 1'b1; wo0 = 16'hA5C3;
        @(negedge clk);
        wv0 = 1'b0;
        wait_idle(0, 400);
        checks++; if (frames[0] - f0 !== 1) $display("FAIL single_frames got %0d required 1", frames[0] - f0); else passed++;
        checks++;
        if (start_q0.size() < 1 || start_q0[0] !== c0 + 2)
            $display("FAIL single_latency got %0d required %0d", (start_q0.size() > 0) ? start_q0[0] : -1, c0 + 2);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s[2] = '{16'h1234, 16'hFEDC};
        int t_idle;
        start_q0.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q0.push_back(word(s[k]));
            wv0 = 1'b1; wo0 = s[k];
            @(negedge clk);
        end
        wv0 = 1'b0;
        wait_idle(0, 600);
        t_idle = cyc;
        checks++;
        if (start_q0.size() != 2) begin
            $display("FAIL b2b_period got %0d frames required 2", start_q0.size());
        end else if (start_q0[1] - start_q0[0] !== 99) begin
            $display("FAIL b2b_period got %0d required 99", start_q0[1] - start_q0[0]);
        end else passed++;
        checks++;
        if (start_q0.size() < 2 || t_idle !== start_q0[1] + 98)
            $display("FAIL b2b_busy_fall got %0d required %0d", t_idle, (start_q0.size() > 1) ? start_q0[1] + 98 : -1);
        else passed++;
    endtask

    task automatic push_six();
        for (int k = 0; k < 6; k++) begin
            if (k < 5) exp_q0.push_back(word(16'h1000 + 16'(k)));
            wv0 = 1'b1; wo0 = 16'h1000 + 16'(k);
            @(negedge clk);
        end
        wv0 = 1'b0;
    endtask

    task automatic test_overflow();
        int f0 = frames[0];
        push_six();
        checks++; if (ovf0 !== 1'b1) $display("FAIL ovf_set got %b required 1", ovf0); else passed++;
        repeat (4) @(negedge clk);
        oc0 = 1'b1;
        @(negedge clk);
        oc0 = 1'b0;
        checks++; if (ovf0 !== 1'b0) $display("FAIL ovf_clear got %b required 0", ovf0); else passed++;
        wait_idle(0, 700);
        checks++; if (frames[0] - f0 !== 5) $display("FAIL ovf_frames got %0d required 5", frames[0] - f0); else passed++;
    endtask

    task automatic test_ovf_coincide();
        int f0 = frames[0];
        push_six();
        repeat (3) @(negedge clk);
        wv0 = 1'b1; wo0 = 16'h7777; oc0 = 1'b1;
        @(negedge clk);
        wv0 = 1'b0; oc0 = 1'b0;
        checks++; if (ovf0 !== 1'b1) $display("FAIL ovf_coincide got %b required 1", ovf0); else passed++;
        oc0 = 1'b1;
        @(negedge clk);
        oc0 = 1'b0;
        checks++; if (ovf0 !== 1'b0) $display("FAIL ovf_coincide_clear got %b required 0", ovf0); else passed++;
        wait_idle(0, 700);
        checks++; if (frames[0] - f0 !== 5) $display("FAIL coincide_frames got %0d required 5", frames[0] - f0); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int rises = 0;
        logic ps;
        abort_ok = 1'b1;
        wv0 = 1'b1; wo0 = 16'h5A5A;
        @(negedge clk);
        wv0 = 1'b0;
        while (!(nbits[0] == 10 && !csb0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 200) $display("FAIL abort_reach_bit10 got timeout required bit 10"); else passed++;
        reset_n = 1'b0;
        wv0 = 1'b1; wo0 = 16'h3333;
        @(negedge clk);
        checks++; if (csb0 !== 1'b1) $display("FAIL abort_csb got %b required 1", csb0); else passed++;
        checks++; if (sclk0 !== 1'b0) $display("FAIL abort_sclk got %b required 0", sclk0); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL abort_busy got %b required 0", busy0); else passed++;
        reset_n = 1'b1;
        wv0 = 1'b0;
        ps = sclk0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sclk0 && !ps) rises++;
            ps = sclk0;
        end
        checks++; if (rises !== 0) $display("FAIL abort_no_resume got %0d sclk edges required 0", rises); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL abort_idle_busy got %b required 0", busy0); else passed++;
    endtask

    task automatic test_fast();
        logic [15:0] s[2] = '{16'h0F0F, 16'h8001};
        int f1 = frames[1];
        start_q1.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q1.push_back(word(s[k]));
            wv1 = 1'b1; wo1 = s[k];
            @(negedge clk);
        end
        wv1 = 1'b0;
        wait_idle(1, 300);
        checks++; if (frames[1] - f1 !== 2) $display("FAIL fast_frames got %0d required 2", frames[1] - f1); else passed++;
        checks++;
        if (start_q1.size() != 2 || start_q1[1] - start_q1[0] !== 50)
            $display("FAIL fast_period got %0d required 50", (start_q1.size() == 2) ? start_q1[1] - start_q1[0] : -1);
        else passed++;
    endtask

    task automatic test_protocol();
        checks++; if (proto_bad !== 0) $display("FAIL sdo_protocol got %0d violations required 0", proto_bad); else passed++;
        checks++; if (exp_q0.size() !== 0) $display("FAIL pending_frames0 got %0d required 0", exp_q0.size()); else passed++;
        checks++; if (exp_q1.size() !== 0) $display("FAIL pending_frames1 got %0d required 0", exp_q1.size()); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_ovf_coincide();
        test_reset_mid_frame();
        test_fast();
        repeat (5) @(negedge clk);
        test_protocol();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion required finish within 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
